enemy_laser_controller: RTL and testbench
=========================================

ENEMY_LASER_CONTROLLER -- requirements
Module: enemy_laser_controller

Interface
REQ-001 SHALL have parameter COOLDOWN_TICKS, default 90: ticks between a strike (or failed select) and the next select.
REQ-002 SHALL have parameter LASER_SPEED, default 4: pixels the laser descends per tick.
REQ-003 SHALL have parameter PLANE_ROW, default 400: laser_v at or above which the laser strikes the plane row.
REQ-004 SHALL have parameter COL_SPACING, default 60, and COL_OFFSET, default 10: enemy i column = formation_h + i*COL_SPACING + COL_OFFSET.
REQ-005 SHALL have parameter ENEMY_HEIGHT, default 20: laser start row offset below enemy_row_v.
REQ-006 clk  input  1  system clock.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 tick  input  1  one-cycle frame pulse; all motion and cooldown advance only on tick.
REQ-009 state  input  2  game state; 1 = playing.
REQ-010 enemy_alive  input  8  bit i set = enemy i alive.
REQ-011 formation_h  input  10  formation left edge.
REQ-012 enemy_row_v  input  10  formation top row.
REQ-013 plane_h  input  10  plane left edge (used only with macro, REQ-033).
REQ-014 laser_active  output  1  laser in flight or striking.
REQ-015 laser_x  output  10  laser column, for rendering.
REQ-016 laser_v  output  10  laser row, for rendering.
REQ-017 enemy_laser_h  output  10  laser_x during STRIKE, else 10'h3FF (parked, never overlaps plane).
REQ-018 shots  output  8  count of lasers fired, wraps 255->0.

Function
REQ-019 FSM states IDLE, COOLDOWN, SELECT, FLY, STRIKE, registered.
REQ-020 IDLE -> COOLDOWN when state==1, loading cooldown counter with COOLDOWN_TICKS.
REQ-021 COOLDOWN: decrement on tick; on tick with counter==1 (or 0) -> SELECT.
REQ-022 LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, advances every clk cycle, never reaches 0.
REQ-023 On SELECT entry, candidate index = lfsr[2:0]; each cycle, if enemy_alive[idx] -> FLY, else idx = (idx+1) mod 8.
REQ-024 After 8 dead candidates in SELECT -> COOLDOWN with counter reloaded; shots unchanged.
REQ-025 On FLY entry: laser_x = column of selected enemy (10-bit, wraps mod 1024), laser_v = enemy_row_v + ENEMY_HEIGHT, shots += 1.
REQ-026 FLY: on tick, laser_v += LASER_SPEED saturating at 1023.
REQ-027 FLY -> STRIKE in the cycle laser_v >= PLANE_ROW is registered (check uses updated value).
REQ-028 STRIKE: enemy_laser_h = laser_x; held until the next tick, then -> COOLDOWN with counter reloaded.
REQ-029 laser_active = 1 exactly in FLY and STRIKE.
REQ-030 Any cycle with state != 1: next state IDLE, laser_active 0, enemy_laser_h 10'h3FF; overrides all transitions, including mid-flight.
REQ-031 Enemy death while its laser flies does not cancel the laser.

Reset
REQ-032 On reset: FSM IDLE, cooldown 0, LFSR 8'hA5, laser_x 0, laser_v 0, laser_active 0, enemy_laser_h 10'h3FF, shots 0; takes effect immediately, independent of clk.

Configuration
REQ-033 Macro ENEMY_LASER_AIMED_EN: when defined, in FLY on each tick laser_x moves 1 px toward plane_h + 10 (no move if equal); when undefined, laser_x is constant during flight and plane_h is unused.

Verification
REQ-034 Reset, state=1, all alive, COOLDOWN_TICKS=90 -> first SELECT after 90th tick; FLY next cycle, shots=1.
REQ-035 enemy_row_v=100, LASER_SPEED=4, PLANE_ROW=400 -> laser_v starts 120, STRIKE after 70th FLY tick (laser_v=400), enemy_laser_h=laser_x for one tick, then 10'h3FF.
REQ-036 enemy_alive=8'b0000_0100, formation_h=50 -> laser_x=180 regardless of LFSR; enemy_alive=0 -> back to COOLDOWN, shots unchanged.
REQ-037 state 1->2 mid-FLY -> next cycle IDLE, laser_active=0, enemy_laser_h=10'h3FF; reset asserted mid-FLY -> REQ-032 values without a clk edge.
REQ-038 With ENEMY_LASER_AIMED_EN, laser_x=180, plane_h=200 -> laser_x reaches 210 after 30 ticks and holds; without macro laser_x stays 180.

Source files
------------

// File: rtl/enemy_laser_controller.sv
// enemy_laser_controller
//   Picks a random living enemy after a cooldown, fires a laser straight
//   down from it, and reports a one-tick strike on the plane row.
//
//   Optional build macro: ENEMY_LASER_AIMED_EN
//     When defined, the laser drifts 1 px per tick toward plane_h + 10
//     during flight. When undefined, laser_x stays fixed and plane_h is
//     not used.
//
//   Ports
//     clk            system clock
//     reset          asynchronous, active-high reset
//     tick           one-cycle frame pulse; motion and cooldown advance on it
//     state          game state, 2'd1 = playing
//     enemy_alive    bit i set = enemy i alive
//     formation_h    formation left edge
//     enemy_row_v    formation top row
//     plane_h        plane left edge (aimed build only)
//     laser_active   laser in flight or striking
//     laser_x        laser column
//     laser_v        laser row
//     enemy_laser_h  laser_x while striking, otherwise 10'h3FF
//     shots          lasers fired, wraps at 255
module enemy_laser_controller #(
    parameter int unsigned COOLDOWN_TICKS = 90,
    parameter int unsigned LASER_SPEED    = 4,
    parameter int unsigned PLANE_ROW      = 400,
    parameter int unsigned COL_SPACING    = 60,
    parameter int unsigned COL_OFFSET     = 10,
    parameter int unsigned ENEMY_HEIGHT   = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [1:0] state,
    input  logic [7:0] enemy_alive,
    input  logic [9:0] formation_h,
    input  logic [9:0] enemy_row_v,
    input  logic [9:0] plane_h,
    output logic       laser_active,
    output logic [9:0] laser_x,
    output logic [9:0] laser_v,
    output logic [9:0] enemy_laser_h,
    output logic [7:0] shots
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COOLDOWN,
        S_SELECT,
        S_FLY,
        S_STRIKE
    } fsm_t;

    fsm_t        fsm_q, fsm_d;
    logic [15:0] cd_q;
    logic [7:0]  lfsr_q;
    logic [2:0]  sel_idx_q;
    logic [2:0]  sel_tries_q;

    logic        playing;
    logic        load_cd, cd_dec, enter_select, sel_adv, launch, fly_step;
    logic [31:0] v_sum, col_sum, start_sum;
    logic [9:0]  v_next, x_next;
    logic        hit;

    assign playing = (state == 2'd1);

    // Speed added in 32 bits so saturation at 1023 holds for any LASER_SPEED.
    assign v_sum     = 32'(laser_v) + LASER_SPEED;
    assign v_next    = (v_sum > 32'd1023) ? 10'h3FF : v_sum[9:0];
    assign hit       = ({22'd0, v_next} >= PLANE_ROW);
    assign col_sum   = 32'(formation_h) + 32'(sel_idx_q) * COL_SPACING + COL_OFFSET;
    assign start_sum = 32'(enemy_row_v) + ENEMY_HEIGHT;

`ifdef ENEMY_LASER_AIMED_EN
    logic [9:0] aim_target;
    assign aim_target = plane_h + 10'd10;
    always_comb begin
        x_next = laser_x;
        if (laser_x < aim_target)
            x_next = laser_x + 10'd1;
        else if (laser_x > aim_target)
            x_next = laser_x - 10'd1;
    end
`else
    logic unused_plane_h;
    assign unused_plane_h = ^plane_h;
    assign x_next = laser_x;
`endif

    always_comb begin
        fsm_d        = fsm_q;
        load_cd      = 1'b0;
        cd_dec       = 1'b0;
        enter_select = 1'b0;
        sel_adv      = 1'b0;
        launch       = 1'b0;
        fly_step     = 1'b0;
        case (fsm_q)
            S_IDLE: begin
                fsm_d   = S_COOLDOWN;
                load_cd = 1'b1;
            end
            S_COOLDOWN: begin
                if (tick) begin
                    if (cd_q <= 16'd1) begin
                        fsm_d        = S_SELECT;
                        enter_select = 1'b1;
                    end else begin
                        cd_dec = 1'b1;
                    end
                end
            end
            S_SELECT: begin
                if (enemy_alive[sel_idx_q]) begin
                    fsm_d  = S_FLY;
                    launch = 1'b1;
                end else if (sel_tries_q == 3'd7) begin
                    fsm_d   = S_COOLDOWN;
                    load_cd = 1'b1;
                end else begin
                    sel_adv = 1'b1;
                end
            end
            S_FLY: begin
                if (tick) begin
                    fly_step = 1'b1;
                    if (hit)
                        fsm_d = S_STRIKE;
                end
            end
            S_STRIKE: begin
                if (tick) begin
                    fsm_d   = S_COOLDOWN;
                    load_cd = 1'b1;
                end
            end
            default: fsm_d = S_IDLE;
        endcase
        // Leaving play beats every transition, including a laser in flight.
        if (!playing) begin
            fsm_d        = S_IDLE;
            load_cd      = 1'b0;
            cd_dec       = 1'b0;
            enter_select = 1'b0;
            sel_adv      = 1'b0;
            launch       = 1'b0;
            fly_step     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            fsm_q <= S_IDLE;
        else
            fsm_q <= fsm_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cd_q        <= '0;
            lfsr_q      <= 8'hA5;
            sel_idx_q   <= '0;
            sel_tries_q <= '0;
            laser_x     <= '0;
            laser_v     <= '0;
            shots       <= '0;
        end else begin
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
            if (load_cd)
                cd_q <= 16'(COOLDOWN_TICKS);
            else if (cd_dec)
                cd_q <= cd_q - 16'd1;
            if (enter_select) begin
                sel_idx_q   <= lfsr_q[2:0];
                sel_tries_q <= '0;
            end else if (sel_adv) begin
                sel_idx_q   <= sel_idx_q + 3'd1;
                sel_tries_q <= sel_tries_q + 3'd1;
            end
            if (launch) begin
                laser_x <= col_sum[9:0];
                laser_v <= start_sum[9:0];
                shots   <= shots + 8'd1;
            end else if (fly_step) begin
                laser_x <= x_next;
                laser_v <= v_next;
            end
        end
    end

    assign laser_active  = playing && ((fsm_q == S_FLY) || (fsm_q == S_STRIKE));
    assign enemy_laser_h = (playing && (fsm_q == S_STRIKE)) ? laser_x : 10'h3FF;

endmodule

// File: tb/tb_enemy_laser_controller.sv
module tb_enemy_laser_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic [1:0] state;
    logic [7:0] enemy_alive;
    logic [9:0] formation_h, enemy_row_v, plane_h;
    logic       laser_active;
    logic [9:0] laser_x, laser_v, enemy_laser_h;
    logic [7:0] shots;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned cyc;
    logic [7:0]  exp_shots;

    enemy_laser_controller dut (
        .clk(clk), .reset(reset), .tick(tick), .state(state),
        .enemy_alive(enemy_alive), .formation_h(formation_h),
        .enemy_row_v(enemy_row_v), .plane_h(plane_h),
        .laser_active(laser_active), .laser_x(laser_x), .laser_v(laser_v),
        .enemy_laser_h(enemy_laser_h), .shots(shots)
    );

    always #5 clk = ~clk;

    // Clock edges seen since reset was last released.
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic step(input logic t);
        tick = t;
        @(posedge clk);
        #1;
        tick = 1'b0;
    endtask

    function automatic logic [7:0] lfsr_after(input int unsigned n);
        logic [7:0] r;
        r = 8'hA5;
        for (int unsigned i = 0; i < n; i++)
            r = {r[6:0], r[7] ^ r[5] ^ r[4] ^ r[3]};
        return r;
    endfunction

    // Runs a full cooldown of 90 ticks with random gaps; returns edge count at the select edge.
    task automatic cooldown_phase(output int unsigned sel_cyc);
        int unsigned ticks, steps;
        logic t, seen_active;
        ticks = 0; steps = 0; seen_active = 1'b0;
        while (ticks < 90) begin
            t = ($urandom_range(0, 2) != 0) || (steps % 4 == 3);
            step(t);
            steps++;
            if (t) ticks++;
            if (laser_active) seen_active = 1'b1;
        end
        sel_cyc = cyc;
        vectors++;
        if (seen_active !== 1'b0) begin
            miscompares++;
            $display("FAIL cooldown_quiet: laser_active seen=%b required=0", seen_active);
        end
    endtask

    task automatic shot(input logic [7:0] alive, input logic [9:0] fh, input logic [9:0] rowv,
                        input logic [9:0] ph, input bit kill_mid);
        int unsigned sc, idx, k, sel, n, x, v, tgt;
        logic [7:0] lf;
        bit done;
        int unsigned steps;
        logic t;
        enemy_alive = alive; formation_h = fh; enemy_row_v = rowv; plane_h = ph;
        cooldown_phase(sc);
        lf = lfsr_after(sc - 1);
        idx = int'(lf[2:0]);
        if (alive == 8'd0) begin
            repeat (8) step(1'b0);
            vectors++;
            if (laser_active !== 1'b0 || shots !== exp_shots || enemy_laser_h !== 10'h3FF) begin
                miscompares++;
                $display("FAIL no_target: active=%b shots=%0d h=%h required 0/%0d/3ff",
                         laser_active, shots, enemy_laser_h, exp_shots);
            end
            return;
        end
        k = 0;
        while (alive[(idx + k) % 8] == 1'b0) k++;
        sel = (idx + k) % 8;
        repeat (k) step(1'b0);
        vectors++;
        if (laser_active !== 1'b0) begin
            miscompares++;
            $display("FAIL select_wait: laser_active=%b required=0 (skip=%0d)", laser_active, k);
        end
        step(1'b0);
        exp_shots = exp_shots + 8'd1;
        x = (fh + sel * 60 + 10) % 1024;
        v = (rowv + 20) % 1024;
        vectors++;
        if (laser_active !== 1'b1 || shots !== exp_shots || laser_x !== 10'(x) || laser_v !== 10'(v)) begin
            miscompares++;
            $display("FAIL launch: active=%b shots=%0d x=%0d v=%0d required 1/%0d/%0d/%0d",
                     laser_active, shots, laser_x, laser_v, exp_shots, x, v);
        end
        tgt = (ph + 10) % 1024;
        n = 0; done = 0; steps = 0;
        while (!done) begin
            t = ($urandom_range(0, 2) != 0) || (steps % 4 == 3);
            step(t);
            steps++;
            if (t) begin
                n++;
                v = (v + 4 > 1023) ? 1023 : v + 4;
`ifdef ENEMY_LASER_AIMED_EN
                if (x < tgt) x = x + 1;
                else if (x > tgt) x = x - 1;
`endif
                if (v >= 400) done = 1;
                if (kill_mid && n == 5) enemy_alive = 8'd0;
                vectors++;
                if (laser_v !== 10'(v) || laser_x !== 10'(x) || laser_active !== 1'b1 ||
                    enemy_laser_h !== (done ? 10'(x) : 10'h3FF)) begin
                    miscompares++;
                    $display("FAIL fly_tick%0d: v=%0d x=%0d active=%b h=%h required v=%0d x=%0d strike=%0d",
                             n, laser_v, laser_x, laser_active, enemy_laser_h, v, x, done);
                end
            end
        end
        repeat ($urandom_range(0, 3)) step(1'b0);
        vectors++;
        if (enemy_laser_h !== 10'(x) || laser_active !== 1'b1) begin
            miscompares++;
            $display("FAIL strike_hold: h=%h active=%b required %h/1", enemy_laser_h, laser_active, 10'(x));
        end
        step(1'b1);
        vectors++;
        if (enemy_laser_h !== 10'h3FF || laser_active !== 1'b0) begin
            miscompares++;
            $display("FAIL strike_end: h=%h active=%b required 3ff/0", enemy_laser_h, laser_active);
        end
    endtask

    task automatic check_reset_values(input string tag);
        vectors++;
        if (laser_active !== 1'b0 || laser_x !== 10'd0 || laser_v !== 10'd0 ||
            enemy_laser_h !== 10'h3FF || shots !== 8'd0) begin
            miscompares++;
            $display("FAIL %s: active=%b x=%0d v=%0d h=%h shots=%0d required 0/0/0/3ff/0",
                     tag, laser_active, laser_x, laser_v, enemy_laser_h, shots);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; state = 2'd0; tick = 1'b0; enemy_alive = '0;
        formation_h = '0; enemy_row_v = '0; plane_h = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        exp_shots = 8'd0;
        check_reset_values("reset");
        repeat (3) step(1'b1);
        check_reset_values("idle_not_playing");
        state = 2'd1;
        step(1'b0);
    endtask

    task automatic test_first_shot();
        shot(8'hFF, 10'($urandom_range(0, 500)), 10'd100, 10'd300, 1'b0);
    endtask

    task automatic test_single_enemy();
        shot(8'b0000_0100, 10'd50, 10'd100, 10'd200, 1'b0);
        shot(8'b0000_0100, 10'd50, 10'd300, 10'd200, 1'b0);
    endtask

    task automatic test_no_enemy();
        shot(8'd0, 10'd50, 10'd100, 10'd0, 1'b0);
    endtask

    task automatic test_kill_midflight();
        shot(8'b1000_0001, 10'd900, 10'd40, 10'd5, 1'b1);
    endtask

    task automatic test_saturation();
        shot(8'hFF, 10'd0, 10'd1002, 10'd0, 1'b0);
    endtask

    task automatic test_random();
        logic [7:0] a;
        for (int i = 0; i < 12; i++) begin
            a = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
            shot(a, 10'($urandom), 10'($urandom), 10'($urandom), bit'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_abort();
        int unsigned sc;
        enemy_alive = 8'hFF;
        cooldown_phase(sc);
        step(1'b0);
        exp_shots = exp_shots + 8'd1;
        repeat (4) step(1'b1);
        state = 2'd2;
        step(1'b0);
        vectors++;
        if (laser_active !== 1'b0 || enemy_laser_h !== 10'h3FF || shots !== exp_shots) begin
            miscompares++;
            $display("FAIL abort: active=%b h=%h shots=%0d required 0/3ff/%0d",
                     laser_active, enemy_laser_h, shots, exp_shots);
        end
        repeat (3) step(1'b1);
        state = 2'd1;
        step(1'b0);
    endtask

    task automatic test_reset_midflight();
        int unsigned sc;
        enemy_alive = 8'hFF;
        cooldown_phase(sc);
        step(1'b0);
        repeat (3) step(1'b1);
        #2 reset = 1'b1;
        #1 check_reset_values("async_reset");
        #1 reset = 1'b0;
        exp_shots = 8'd0;
        @(posedge clk);
        #1;
        check_reset_values("post_reset");
        step(1'b0);
    endtask

    initial begin
        test_reset();
        test_first_shot();
        test_single_enemy();
        test_no_enemy();
        test_kill_midflight();
        test_saturation();
        test_random();
        test_abort();
        test_reset_midflight();
        test_first_shot();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
